// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Opcode encodings match the ALU's Aluop input bit for bit.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    AND  = 3'b000,
    OR   = 3'b001,
    XOR  = 3'b010,
    ADD  = 3'b011,
    SUB  = 3'b100,
    SLT  = 3'b101,
    SLTE = 3'b110,
    EQ   = 3'b111
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               grant_any
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;

  // Rotating a doubled copy puts requester ptr at bit 0, so a fixed
  // low-to-high priority scan of the rotated vector is the round-robin order.
  assign doubled = {valid, valid};
  assign rotated = NUM_REQ'(doubled >> ptr);

  always_comb begin
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && rotated[k]) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        grant     = ID_W'(idx);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between NUM_REQ
// requesters, returning results on a single tagged response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*3-1:0]      req_aluop,
  output logic [DATA_W-1:0]         alu_op1,
  output logic [DATA_W-1:0]         alu_op2,
  output logic [2:0]                alu_aluop,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_equal,
  input  logic                      alu_lessthan,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_equal,
  output logic                      rsp_lessthan,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_EXEC = 2'(EXEC);
  localparam logic [1:0] ST_RESP = 2'(RESP);

  logic [1:0]        state, state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic              grant_any;
  logic              can_accept;
  logic              fire;
  logic [ID_W-1:0]   op_id;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [2:0]        aluop_q;
  logic [DATA_W-1:0] sel_op1, sel_op2;
  logic [2:0]        sel_aluop;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_any (grant_any)
  );

  // Gating with rst_n keeps req_ready at 0 while reset is held.
  assign can_accept = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
  assign fire       = rst_n && can_accept && grant_any;

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[grant] = 1'b1;
  end

  always_comb begin
    sel_op1   = '0;
    sel_op2   = '0;
    sel_aluop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_op1   = req_op1[i*DATA_W +: DATA_W];
        sel_op2   = req_op2[i*DATA_W +: DATA_W];
        sel_aluop = req_aluop[i*3 +: 3];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (fire) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = fire ? ST_EXEC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Response registers are separate from the operand registers so a
  // back-to-back accept in RESP cannot disturb the response being handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      op_id        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      aluop_q      <= '0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_equal    <= 1'b0;
      rsp_lessthan <= 1'b0;
    end else begin
      state <= state_next;
      if (fire) begin
        op_id   <= grant;
        op1_q   <= sel_op1;
        op2_q   <= sel_op2;
        aluop_q <= sel_aluop;
        rr_ptr  <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      end
      if (state == ST_EXEC) begin
        rsp_id       <= op_id;
        rsp_result   <= alu_result;
        rsp_equal    <= alu_equal;
        rsp_lessthan <= alu_lessthan;
      end
    end
  end

  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_aluop = aluop_q;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a 2-requester and a 3-requester instance,
// each driven by a behavioural ALU, with expected responses queued up front.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] result;
    logic       eq;
    logic       lt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t q2[$];
  exp_t q3[$];

  // ---------------- 2-requester instance ----------------
  logic [1:0]  r2_valid = '0, r2_ready;
  logic [15:0] r2_op1 = '0, r2_op2 = '0;
  logic [5:0]  r2_aluop = '0;
  logic [7:0]  a2_op1, a2_op2, a2_result;
  logic [2:0]  a2_aluop;
  logic        a2_eq, a2_lt;
  logic        rsp_valid2, rsp_ready2 = 1'b0, rsp_eq2, rsp_lt2, busy2;
  logic [0:0]  rsp_id2;
  logic [7:0]  rsp_res2;

  alu_arbiter #(.NUM_REQ(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r2_valid), .req_ready(r2_ready),
    .req_op1(r2_op1), .req_op2(r2_op2), .req_aluop(r2_aluop),
    .alu_op1(a2_op1), .alu_op2(a2_op2), .alu_aluop(a2_aluop),
    .alu_result(a2_result), .alu_equal(a2_eq), .alu_lessthan(a2_lt),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2),
    .rsp_result(rsp_res2), .rsp_equal(rsp_eq2), .rsp_lessthan(rsp_lt2),
    .busy(busy2)
  );

  // ---------------- 3-requester instance ----------------
  logic [2:0]  r3_valid = '0, r3_ready;
  logic [23:0] r3_op1 = '0, r3_op2 = '0;
  logic [8:0]  r3_aluop = '0;
  logic [7:0]  a3_op1, a3_op2, a3_result;
  logic [2:0]  a3_aluop;
  logic        a3_eq, a3_lt;
  logic        rsp_valid3, rsp_ready3 = 1'b1, rsp_eq3, rsp_lt3, busy3;
  logic [1:0]  rsp_id3;
  logic [7:0]  rsp_res3;

  alu_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_valid), .req_ready(r3_ready),
    .req_op1(r3_op1), .req_op2(r3_op2), .req_aluop(r3_aluop),
    .alu_op1(a3_op1), .alu_op2(a3_op2), .alu_aluop(a3_aluop),
    .alu_result(a3_result), .alu_equal(a3_eq), .alu_lessthan(a3_lt),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_result(rsp_res3), .rsp_equal(rsp_eq3), .rsp_lessthan(rsp_lt3),
    .busy(busy3)
  );

  // Behavioural ALU (unsigned compares) standing in for the real instance.
  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (aluop_t'(op))
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      ADD:     return a + b;
      SUB:     return a - b;
      SLT:     return {7'd0, a < b};
      SLTE:    return {7'd0, a <= b};
      default: return {7'd0, a == b};
    endcase
  endfunction

  always_comb begin
    a2_result = alu_model(a2_aluop, a2_op1, a2_op2);
    a2_eq     = (a2_op1 == a2_op2);
    a2_lt     = (a2_op1 < a2_op2);
    a3_result = alu_model(a3_aluop, a3_op1, a3_op2);
    a3_eq     = (a3_op1 == a3_op2);
    a3_lt     = (a3_op1 < a3_op2);
  end

  // A requester must hold valid until it is accepted.
  for (genvar g = 0; g < 2; g++) begin : g_hold2
    assert property (@(posedge clk) disable iff (!rst_n)
      (r2_valid[g] && !r2_ready[g]) |=> r2_valid[g]);
  end
  for (genvar g = 0; g < 3; g++) begin : g_hold3
    assert property (@(posedge clk) disable iff (!rst_n)
      (r3_valid[g] && !r3_ready[g]) |=> r3_valid[g]);
  end

  // Monitors: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid2 === 1'b1 && rsp_ready2 === 1'b1) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("[TB] FAIL rsp2_unexpected: got id=%0d res=%h, required no response", rsp_id2, rsp_res2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        if ({3'(rsp_id2), rsp_res2, rsp_eq2, rsp_lt2} !== e) begin
          fails++;
          $display("[TB] FAIL rsp2: got id=%0d res=%h eq=%b lt=%b, required id=%0d res=%h eq=%b lt=%b",
                   rsp_id2, rsp_res2, rsp_eq2, rsp_lt2, e.id, e.result, e.eq, e.lt);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid3 === 1'b1 && rsp_ready3 === 1'b1) begin
      tests++;
      if (rsp_id3 === 2'd3) begin
        fails++;
        $display("[TB] FAIL rsp3_id_range: got id=3, required id<3");
      end
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("[TB] FAIL rsp3_unexpected: got id=%0d res=%h, required no response", rsp_id3, rsp_res3);
      end else begin
        exp_t e;
        e = q3.pop_front();
        if ({3'(rsp_id3), rsp_res3, rsp_eq3, rsp_lt3} !== e) begin
          fails++;
          $display("[TB] FAIL rsp3: got id=%0d res=%h eq=%b lt=%b, required id=%0d res=%h eq=%b lt=%b",
                   rsp_id3, rsp_res3, rsp_eq3, rsp_lt3, e.id, e.result, e.eq, e.lt);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit three, input int idx, input bit v,
                               input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [2:0]  vm;
    logic [23:0] dm;
    logic [8:0]  om;
    vm = 3'd1 << idx;
    dm = 24'hFF << (8 * idx);
    om = 9'h7 << (3 * idx);
    if (three) begin
      r3_valid = v ? (r3_valid | vm) : (r3_valid & ~vm);
      r3_op1   = (r3_op1 & ~dm) | (24'(a) << (8 * idx));
      r3_op2   = (r3_op2 & ~dm) | (24'(b) << (8 * idx));
      r3_aluop = (r3_aluop & ~om) | (9'(op) << (3 * idx));
    end else begin
      r2_valid = v ? (r2_valid | vm[1:0]) : (r2_valid & ~vm[1:0]);
      r2_op1   = (r2_op1 & ~dm[15:0]) | (16'(a) << (8 * idx));
      r2_op2   = (r2_op2 & ~dm[15:0]) | (16'(b) << (8 * idx));
      r2_aluop = (r2_aluop & ~om[5:0]) | (6'(op) << (3 * idx));
    end
  endtask

  task automatic drop_valid(input bit three, input int idx);
    logic [2:0] vm;
    vm = 3'd1 << idx;
    if (three) r3_valid = r3_valid & ~vm;
    else       r2_valid = r2_valid & ~vm[1:0];
  endtask

  task automatic expect_rsp(input bit three, input logic [2:0] id, input logic [7:0] res,
                            input logic eq, input logic lt);
    if (three) q3.push_back({id, res, eq, lt});
    else       q2.push_back({id, res, eq, lt});
  endtask

  // Waits (bounded) for a request handshake on requester idx; returns at
  // posedge+1 after the accepting edge, with the negedge count and whether
  // busy stayed high on every sampled negedge.
  task automatic wait_hs(input bit three, input int idx, output int cycles, output bit busy_all);
    logic [2:0] hv, vm;
    bit done;
    done = 0; cycles = 0; busy_all = 1;
    vm = 3'd1 << idx;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (!(three ? busy3 : busy2)) busy_all = 0;
      hv = three ? (r3_valid & r3_ready) : {1'b0, r2_valid & r2_ready};
      if (|(hv & vm)) done = 1;
    end
    @(posedge clk); #1;
    if (!done) begin
      tests++; fails++;
      $display("[TB] FAIL hs_timeout: requester %0d not accepted within 20 cycles", idx);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q2.size() != 0 || q3.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (q2.size() != 0 || q3.size() != 0) begin
      tests++; fails++;
      $display("[TB] FAIL drain: got %0d/%0d responses outstanding, required 0", q2.size(), q3.size());
      q2.delete(); q3.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    bit ball;
    int seen;

    // Reset state, before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_req_ready", 32'(r2_ready), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid2), 0);
    checkOutput("reset_busy", 32'(busy2), 0);
    checkOutput("reset_alu_ops", {8'd0, a2_op1, a2_op2, 5'd0, a2_aluop}, 0);
    checkOutput("reset_rsp", {21'd0, rsp_id2, rsp_res2, rsp_eq2, rsp_lt2}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single op: ADD 3+2 from requester 0.
    rsp_ready2 = 1'b1;
    applyStimulus(0, 0, 1, ADD, 8'h03, 8'h02);
    expect_rsp(0, 0, 8'h05, 0, 0);
    @(negedge clk);
    checkOutput("single_req_ready", 32'(r2_ready), 32'b01);
    @(posedge clk); #1;
    drop_valid(0, 0);
    @(negedge clk);
    checkOutput("single_exec_busy", 32'(busy2), 1);
    checkOutput("single_exec_rsp_valid", 32'(rsp_valid2), 0);
    checkOutput("single_exec_alu", {13'd0, a2_op1, a2_op2, a2_aluop}, {13'd0, 8'h03, 8'h02, 3'(ADD)});
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("single_latency_rsp_valid", 32'(rsp_valid2), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("single_idle_busy", 32'(busy2), 0);
    checkOutput("single_hold_alu_op1", 32'(a2_op1), 32'h03);
    @(posedge clk); #1;

    // Contention with rr_ptr freshly reset: order 0,1,0,1.
    do_reset();
    rsp_ready2 = 1'b1;
    applyStimulus(0, 0, 1, AND, 8'h0F, 8'hF0);
    applyStimulus(0, 1, 1, EQ, 8'h01, 8'h01);
    expect_rsp(0, 0, 8'h00, 0, 1);
    expect_rsp(0, 1, 8'h01, 1, 0);
    expect_rsp(0, 0, 8'h00, 0, 1);
    expect_rsp(0, 1, 8'h01, 1, 0);
    wait_hs(0, 0, cyc, ball);
    checkOutput("cont_first_grant_latency", 32'(cyc), 1);
    wait_hs(0, 1, cyc, ball);
    checkOutput("cont_b2b_gap", 32'(cyc), 2);
    wait_hs(0, 0, cyc, ball);
    drop_valid(0, 0);
    wait_hs(0, 1, cyc, ball);
    drop_valid(0, 1);
    drain();

    // Backpressure: response held 5 cycles, pending req1 waits.
    rsp_ready2 = 1'b0;
    applyStimulus(0, 0, 1, XOR, 8'hAA, 8'h55);
    expect_rsp(0, 0, 8'hFF, 0, 0);
    expect_rsp(0, 1, 8'h33, 0, 0);
    wait_hs(0, 0, cyc, ball);
    drop_valid(0, 0);
    applyStimulus(0, 1, 1, OR, 8'h30, 8'h03);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_hold", {13'd0, rsp_valid2, 3'(rsp_id2), rsp_res2, 5'd0, r2_ready},
                  {13'd0, 1'b1, 3'd0, 8'hFF, 5'd0, 2'b00});
      @(posedge clk); #1;
    end
    rsp_ready2 = 1'b1;
    wait_hs(0, 1, cyc, ball);
    checkOutput("bp_accept_on_ready_rise", 32'(cyc), 1);
    drop_valid(0, 1);
    drain();

    // Back-to-back SUB 3-2 from requester 1.
    applyStimulus(0, 1, 1, SUB, 8'h03, 8'h02);
    for (int k = 0; k < 4; k++) expect_rsp(0, 1, 8'h01, 0, 0);
    wait_hs(0, 1, cyc, ball);
    for (int k = 1; k < 4; k++) begin
      wait_hs(0, 1, cyc, ball);
      checkOutput("b2b_gap", 32'(cyc), 2);
      checkOutput("b2b_busy", 32'(ball), 1);
    end
    drop_valid(0, 1);
    drain();

    // Reset mid-EXEC: asynchronous clear, no stale response afterwards.
    applyStimulus(0, 0, 1, ADD, 8'h03, 8'h02);
    wait_hs(0, 0, cyc, ball);
    drop_valid(0, 0);
    applyStimulus(0, 1, 1, OR, 8'h30, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy2), 0);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid2), 0);
    checkOutput("midrst_req_ready", 32'(r2_ready), 0);
    checkOutput("midrst_alu_ops", {8'd0, a2_op1, a2_op2, 5'd0, a2_aluop}, 0);
    drop_valid(0, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid2 || busy2) seen++;
    end
    checkOutput("midrst_no_stale", 32'(seen), 0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 1, OR, 8'h30, 8'h03);
    applyStimulus(0, 1, 1, SLT, 8'h10, 8'h20);
    expect_rsp(0, 0, 8'h33, 0, 0);
    expect_rsp(0, 1, 8'h01, 0, 1);
    @(negedge clk);
    checkOutput("midrst_rr_ptr_zero", 32'(r2_ready), 32'b01);
    @(posedge clk); #1;
    drop_valid(0, 0);
    wait_hs(0, 1, cyc, ball);
    drop_valid(0, 1);
    drain();

    // Three requesters: grant order 0,1,2,0,1,2.
    applyStimulus(1, 0, 1, SLTE, 8'h20, 8'h20);
    applyStimulus(1, 1, 1, XOR, 8'h0F, 8'h0F);
    applyStimulus(1, 2, 1, SUB, 8'h05, 8'h07);
    for (int k = 0; k < 2; k++) begin
      expect_rsp(1, 0, 8'h01, 1, 0);
      expect_rsp(1, 1, 8'h00, 1, 0);
      expect_rsp(1, 2, 8'hFE, 0, 1);
    end
    for (int k = 0; k < 6; k++) begin
      wait_hs(1, k % 3, cyc, ball);
      if (k >= 3) drop_valid(1, k % 3);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational 8-bit ALU (AND/OR/XOR/ADD/SUB/SLT/SLTE/EQ) between NUM_REQ requesters using round-robin arbitration. Each requester offers one operation per valid/ready handshake. The arbiter registers the winning operands, drives the ALU for one cycle, captures the result and flags, and returns them on a single tagged response channel. It sits between the ALU instance and its clients: the fetch/execute sequencer and the branch-compare unit.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, $clog2(NUM_REQ) (minimum 1), width of requester tag

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_op1  in  NUM_REQ*8  packed operand 1, requester i at [8i+7:8i]
req_op2  in  NUM_REQ*8  packed operand 2
req_aluop  in  NUM_REQ*3  packed 3-bit ALU opcode
alu_op1  out  8  to ALU op1
alu_op2  out  8  to ALU op2
alu_aluop  out  3  to ALU Aluop
alu_result  in  8  from ALU output
alu_equal  in  1  from ALU equal
alu_lessthan  in  1  from ALU lessThan
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of requester that issued the op
rsp_result  out  8  captured ALU result
rsp_equal  out  1  captured equal flag
rsp_lessthan  out  1  captured lessThan flag
busy  out  1  high in EXEC or RESP

Behaviour:
- States: IDLE, EXEC, RESP. Reset state IDLE.
- Reset values: all outputs 0. rr_ptr=0. Operand, opcode and result registers 0.
- rst_n low at any time, including mid-EXEC/RESP: the FSM asynchronously returns to IDLE. The in-flight op is dropped and no response is issued.
- Grant selection (combinational): the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- req_ready[g]=1 only for the granted g, and only when the FSM can accept: state IDLE, or state RESP with rsp_ready=1.
- Handshake on requester g (req_valid[g] & req_ready[g]) latches op1/op2/aluop/g and sets rr_ptr=(g+1) mod NUM_REQ. Next state is EXEC.
- req_ready must not depend on any requester's req_valid other than through the grant search. Requesters may not withdraw valid before the handshake; a bench assertion checks this.
- EXEC: alu_op1/op2/aluop driven from the latched registers. Result, equal and lessThan are captured at the end of the cycle. Next state is RESP.
- alu_* outputs hold their last latched values outside EXEC; no glitching to 0.
- RESP: rsp_valid=1, with rsp_* stable until rsp_ready.
  - rsp_ready=0: stay in RESP.
  - rsp_ready=1 with no request: go to IDLE.
  - rsp_ready=1 with a granted request: accept it in the same cycle and go to EXEC (back-to-back).
- Latency: handshake at cycle T means rsp_valid at T+2. Sustained throughput is 1 op per 2 cycles when rsp_ready is held high.
- All 8 opcode values are legal and passed through unchanged. The arbiter performs no arithmetic.
- rsp_id width ID_W. When NUM_REQ is not a power of 2, unused id codes never appear.

Decomposition:
- alu_pkg holds:
  - aluop_t enum: AND=000, OR=001, XOR=010, ADD=011, SUB=100, SLT=101, SLTE=110, EQ=111
  - localparam DATA_W=8
  - arb_state_t enum {IDLE, EXEC, RESP}
- One sub-module, rr_pick: combinational round-robin search. Inputs: valid vector and rr_ptr. Outputs: grant index and grant_any.

Test Plan:
- Single op: req 0 valid, op1=0x03, op2=0x02, aluop=ADD, in IDLE -> req_ready[0]=1 that cycle. rsp_valid two cycles later with rsp_id=0, rsp_result=0x05.
- Contention: both valid from IDLE with rr_ptr=0, req0 AND 0x0F,0xF0 and req1 EQ 0x01,0x01, rsp_ready=1 -> req0 served first (result 0x00); req1 accepted in that RESP cycle, giving rsp_id=1, rsp_equal=1. Grant order 0,1,0,1 under continuous requests.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid held with rsp_* unchanged and req_ready all 0. Pending requests are accepted only on the cycle rsp_ready rises.
- Back-to-back: req1 continuously valid (SUB 0x03,0x02), rsp_ready=1 -> a response every 2 cycles with rsp_result=0x01, and busy stays high.
- Reset mid-op: rst_n low during EXEC -> all outputs 0 immediately with no clock needed. After release: state IDLE, rr_ptr=0, no stale response emitted.
- NUM_REQ=3 build: all three valid continuously -> grants 0,1,2,0 and rsp_id never equals 3.
